// File: rtl/aes_inv_round_unit_if.sv
// rtl/aes_inv_round_unit_if.sv - round-in / round-out handshake bundle for the inverse AES round unit
interface aes_inv_round_unit_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         final_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, round_key, final_round, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, round_key, final_round, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/aes_inv_round_unit.sv
// rtl/aes_inv_round_unit.sv - iterative AES inverse round, InvSubBytes time-multiplexed over LANES lanes
module aes_inv_round_unit #(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  aes_inv_round_unit_if.slave bus
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("aes_inv_round_unit: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [3:0] LAST_CNT = 4'(16 / LANES - 1);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  state_t       r_state, w_next;
  logic [127:0] r_work, r_key, r_out;
  logic         r_final;
  logic [3:0]   r_cnt;
  logic [127:0] w_shift, w_sub, w_mix_in, w_mix;

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
    return v[8*(15-i) +: 8];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine first, then the multiplicative inverse as x^254 by repeated squaring.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;
    b   = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    sq  = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[8*(15-(r+4*c)) +: 8] = get_byte(bus.state_in, r + 4*((c - r + 4) % 4));
      end
    end
  end

  always_comb begin
    w_sub = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_sub[8*(15-((int'(r_cnt)*LANES + l) & 15)) +: 8] =
        inv_sbox(get_byte(r_work, (int'(r_cnt)*LANES + l) & 15));
    end
  end

  always_comb begin
    w_mix_in = r_work ^ r_key;
    w_mix    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[8*(15-(r+4*c)) +: 8] =
            gf_mul(8'h0e, get_byte(w_mix_in, 4*c + r))
          ^ gf_mul(8'h0b, get_byte(w_mix_in, 4*c + (r+1)%4))
          ^ gf_mul(8'h0d, get_byte(w_mix_in, 4*c + (r+2)%4))
          ^ gf_mul(8'h09, get_byte(w_mix_in, 4*c + (r+3)%4));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = SUB;
      SUB:     if (r_cnt == LAST_CNT) w_next = MIX;
      MIX:     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_out = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work  <= '0;
      r_key   <= '0;
      r_final <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_work  <= w_shift;
          r_key   <= bus.round_key;
          r_final <= bus.final_round;
          r_cnt   <= '0;
        end
        SUB: begin
          r_work <= w_sub;
          r_cnt  <= r_cnt + 4'd1;
        end
        MIX:     r_out <= r_final ? w_mix_in : w_mix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_unit.sv
// tb/tb_aes_inv_round_unit.sv - self-checking bench for aes_inv_round_unit across LANES = 4, 1, 2, 8, 16
module tb_aes_inv_round_unit;

  localparam int NDUT  = 5;
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid_a  [NDUT];
  logic         final_a     [NDUT];
  logic         out_ready_a [NDUT];
  logic [127:0] state_in_a  [NDUT];
  logic [127:0] key_a       [NDUT];
  logic [NDUT-1:0] in_ready_v;
  logic [NDUT-1:0] out_valid_v;
  logic [127:0] state_out_a [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
      aes_inv_round_unit_if u_if ();
      assign u_if.in_valid    = in_valid_a[g];
      assign u_if.state_in    = state_in_a[g];
      assign u_if.round_key   = key_a[g];
      assign u_if.final_round = final_a[g];
      assign u_if.out_ready   = out_ready_a[g];
      assign in_ready_v[g]    = u_if.in_ready;
      assign out_valid_v[g]   = u_if.out_valid;
      assign state_out_a[g]   = u_if.state_out;
      aes_inv_round_unit #(.LANES(L)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
      );
    end
  endgenerate

  function automatic int lanes_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: tables derived from the forward S-box definition, plain matrix arithmetic.
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key, input logic fin);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] o [16];
    logic [7:0] coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r + 4*((c - r + 4) % 4)];
    for (int i = 0; i < 16; i++) t[i] = isbox[t[i]] ^ key[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r+4*c] = 8'h00;
        for (int j = 0; j < 4; j++) o[r+4*c] = o[r+4*c] ^ tb_mul(coef[(j - r + 4) % 4], t[j+4*c]);
      end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = fin ? t[i] : o[i];
    return res;
  endfunction

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         fin;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [3];

  task automatic run_round(input int k, input vec_t v, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    check({tag, " in_ready before"}, 128'(in_ready_v[k]), 128'd1);
    state_in_a[k]  = v.st;
    key_a[k]       = v.key;
    final_a[k]     = v.fin;
    in_valid_a[k]  = 1'b1;
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    while (!out_valid_v[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " state_out"}, state_out_a[k], v.exp);
    @(posedge clk); #1;
    check({tag, " out_valid after xfer"}, 128'(out_valid_v[k]), 128'd0);
    check({tag, " in_ready after xfer"}, 128'(in_ready_v[k]), 128'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] q_exp [$];
    vec_t rv;
    int lat;

    build_tables();
    vecs[0] = '{st: 128'h6353e08c0960e104cd70b751bacad0e7, key: 128'h000102030405060708090a0b0c0d0e0f,
                fin: 1'b1, exp: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{st: {16{8'h63}}, key: {4{32'h8e4da1bc}}, fin: 1'b0, exp: {4{32'hdb135345}}};
    vecs[2] = '{st: {16{8'h63}}, key: {4{32'h01010101}}, fin: 1'b0, exp: {4{32'h01010101}}};

    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      in_valid_a[k] = 1'b0; final_a[k] = 1'b0; out_ready_a[k] = 1'b1;
      state_in_a[k] = '0;   key_a[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset L%0d in_ready", lanes_of(k)), 128'(in_ready_v[k]), 128'd1);
      check($sformatf("reset L%0d out_valid", lanes_of(k)), 128'(out_valid_v[k]), 128'd0);
      check($sformatf("reset L%0d state_out", lanes_of(k)), state_out_a[k], 128'd0);
    end
    rst = 1'b0;

    for (int k = 0; k < NDUT; k++)
      for (int v = 0; v < 3; v++)
        run_round(k, vecs[v], 16 / lanes_of(k) + 1, $sformatf("L%0d vec%0d", lanes_of(k), v));

    // Backpressure: result must hold and no new round may start while DONE stalls.
    state_in_a[0] = vecs[0].st; key_a[0] = vecs[0].key; final_a[0] = vecs[0].fin;
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    lat = 0;
    while (!out_valid_v[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 128'(lat), 128'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid_a[0] = 1'($urandom_range(0, 1));
      state_in_a[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("bp hold %0d state_out", i), state_out_a[0], vecs[0].exp);
      check($sformatf("bp hold %0d in_ready", i), 128'(in_ready_v[0]), 128'd0);
      check($sformatf("bp hold %0d out_valid", i), 128'(out_valid_v[0]), 128'd1);
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 128'(out_valid_v[0]), 128'd0);
    check("bp release in_ready", 128'(in_ready_v[0]), 128'd1);
    check("bp release state_out", state_out_a[0], vecs[0].exp);

    // Reset during the second SUB cycle.
    state_in_a[0] = vecs[1].st; key_a[0] = vecs[1].key; final_a[0] = vecs[1].fin;
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset in_ready", 128'(in_ready_v[0]), 128'd1);
    check("midreset out_valid", 128'(out_valid_v[0]), 128'd0);
    check("midreset state_out", state_out_a[0], 128'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("midreset idle %0d out_valid", i), 128'(out_valid_v[0]), 128'd0);
    end
    run_round(0, vecs[0], 5, "after reset");

    // Random round-trip against the model with gaps on both handshakes.
    fork
      begin : driver
        logic rdy;
        logic acc;
        int   tries;
        for (int n = 0; n < NRAND; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          rv.st  = {$urandom, $urandom, $urandom, $urandom};
          rv.key = {$urandom, $urandom, $urandom, $urandom};
          rv.fin = 1'($urandom_range(0, 1));
          state_in_a[0] = rv.st; key_a[0] = rv.key; final_a[0] = rv.fin;
          in_valid_a[0] = 1'b1;
          acc = 1'b0;
          tries = 0;
          while (!acc && tries < 200) begin
            @(negedge clk);
            rdy = in_ready_v[0];
            @(posedge clk); #1;
            acc = rdy;
            tries++;
          end
          in_valid_a[0] = 1'b0;
          if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand accept: got no accept after %0d cycles expected accept", tries);
            break;
          end
          q_exp.push_back(model_round(rv.st, rv.key, rv.fin));
        end
      end
      begin : monitor
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < NRAND && cyc < 60000) begin
          @(posedge clk); #1;
          out_ready_a[0] = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid_v[0] && out_ready_a[0]) begin
            if (q_exp.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rand dup: got output %h expected none pending", state_out_a[0]);
            end else begin
              check($sformatf("rand data %0d", got), state_out_a[0], q_exp.pop_front());
            end
            got++;
          end
          cyc++;
        end
        check("rand count", 128'(got), 128'(NRAND));
      end
    join
    check("rand leftover", 128'(q_exp.size()), 128'd0);
    out_ready_a[0] = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
